// File: rtl/pulse_replayer_pkg.sv
// Shared definitions for the pulse replayer: FSM state encoding, default
// timing/queue constants and the counter width helper.
package pulse_replayer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int DEF_ON_TICKS  = 5_000_000;
  localparam int DEF_OFF_TICKS = 5_000_000;
  localparam int DEF_DEPTH     = 7;

  // The counter only ever holds values up to max(on, off) - 1.
  function automatic int cntWidth(input int onTicks, input int offTicks);
    int maxTicks;
    maxTicks = (onTicks > offTicks) ? onTicks : offTicks;
    return (maxTicks > 1) ? $clog2(maxTicks) : 1;
  endfunction

endpackage

// File: rtl/pulse_replayer_tick_counter.sv
// Loadable down-counter shared by the ON and OFF phases; stops at zero
// instead of wrapping.
module tick_counter #(
  parameter int WIDTH = 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_enable,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pulse_replayer.sv
// Stretches each single-clock event strobe into an ON_TICKS high pulse
// followed by an OFF_TICKS gap, queueing up to DEPTH events meanwhile.
module pulse_replayer
  import pulse_replayer_pkg::*;
#(
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int DEPTH     = DEF_DEPTH
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       In,
  input  logic                       Clear,
  output logic                       Out,
  output logic                       Busy,
  output logic [$clog2(DEPTH+1)-1:0] Pending,
  output logic                       Overflow
);

  localparam int CNT_W  = cntWidth(ON_TICKS, OFF_TICKS);
  localparam int PEND_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(DEPTH);

  state_t            r_state;
  state_t            w_nextState;
  logic [PEND_W-1:0] r_pending;
  logic [PEND_W-1:0] w_nextPending;
  logic              r_out;
  logic              r_overflow;
  logic              w_event;
  logic              w_queueEvent;
  logic              w_drop;
  logic              w_load;
  logic [CNT_W-1:0]  w_loadValue;
  logic              w_dec;
  logic              w_zero;

  tick_counter #(
    .WIDTH(CNT_W)
  ) u_tick_counter (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .i_load  (w_load),
    .i_value (w_loadValue),
    .i_enable(w_dec),
    .o_zero  (w_zero)
  );

  // Clear discards any strobe sampled alongside it.
  always_comb begin
    w_event       = In && !Clear;
    w_nextState   = r_state;
    w_nextPending = r_pending;
    w_queueEvent  = 1'b0;
    w_drop        = 1'b0;
    w_load        = 1'b0;
    w_loadValue   = ON_LOAD;
    w_dec         = 1'b0;

    if (Clear) begin
      w_nextPending = '0;
    end

    case (r_state)
      IDLE: begin
        if (w_event) begin
          w_nextState = ON;
          w_load      = 1'b1;
          w_loadValue = ON_LOAD;
        end
      end
      ON: begin
        w_queueEvent = w_event;
        if (w_zero) begin
          w_nextState = OFF;
          w_load      = 1'b1;
          w_loadValue = OFF_LOAD;
        end else begin
          w_dec = 1'b1;
        end
      end
      OFF: begin
        if (!w_zero) begin
          w_dec        = 1'b1;
          w_queueEvent = w_event;
        end else if (Clear) begin
          w_nextState = IDLE;
        end else if (r_pending != '0) begin
          // A strobe arriving now takes the slot freed by the dequeued event.
          w_nextState = ON;
          w_load      = 1'b1;
          w_loadValue = ON_LOAD;
          if (!w_event) begin
            w_nextPending = r_pending - PEND_W'(1);
          end
        end else if (w_event) begin
          w_nextState = ON;
          w_load      = 1'b1;
          w_loadValue = ON_LOAD;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (w_queueEvent) begin
      if (r_pending == PEND_MAX) begin
        w_drop = 1'b1;
      end else begin
        w_nextPending = r_pending + PEND_W'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_out      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_pending  <= w_nextPending;
      r_out      <= (w_nextState == ON);
      r_overflow <= w_drop;
    end
  end

  assign Out      = r_out;
  assign Busy     = (r_state != IDLE);
  assign Pending  = r_pending;
  assign Overflow = r_overflow;

endmodule

// File: tb/tb_pulse_replayer.sv
// Scoreboard bench for pulse_replayer: a blink-period reference model feeds
// expected outputs into a queue that a per-cycle monitor drains.
module tb_pulse_replayer;

  localparam int ON_T  = 3;
  localparam int OFF_T = 2;
  localparam int DEP   = 2;
  localparam int PW    = $clog2(DEP + 1);

  logic          Clock   = 1'b0;
  logic          Reset_n = 1'b0;
  logic          In      = 1'b0;
  logic          Clear   = 1'b0;
  logic          Out;
  logic          Busy;
  logic [PW-1:0] Pending;
  logic          Overflow;

  typedef struct {
    logic out;
    logic busy;
    int   pending;
    logic overflow;
  } expect_t;

  expect_t expQ[$];
  int      totalChecks = 0;
  int      badChecks   = 0;
  int      cycleNo     = 0;

  bit mActive;
  int mPos;
  int mPending;
  bit mOverflow;

  pulse_replayer #(
    .ON_TICKS (ON_T),
    .OFF_TICKS(OFF_T),
    .DEPTH    (DEP)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .In      (In),
    .Clear   (Clear),
    .Out     (Out),
    .Busy    (Busy),
    .Pending (Pending),
    .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    totalChecks++;
    if (got !== want) begin
      badChecks++;
      $display("[TB] FAIL %s cycle=%0d got=%0d want=%0d", name, cycleNo, got, want);
    end
  endtask

  function automatic void modelReset();
    mActive   = 1'b0;
    mPos      = 0;
    mPending  = 0;
    mOverflow = 1'b0;
  endfunction

  // A blink is one period of ON_T + OFF_T cycles; mPos is the cycle index in it.
  function automatic void modelStep(input bit inBit, input bit clr);
    bit ev;
    ev = inBit && !clr;
    mOverflow = 1'b0;
    if (!mActive) begin
      if (clr) mPending = 0;
      if (ev) begin
        mActive = 1'b1;
        mPos    = 0;
      end
    end else if (mPos == ON_T + OFF_T - 1) begin
      if (clr) begin
        mActive  = 1'b0;
        mPending = 0;
      end else if (mPending > 0) begin
        mPos = 0;
        if (!ev) mPending--;
      end else if (ev) begin
        mPos = 0;
      end else begin
        mActive = 1'b0;
      end
    end else begin
      mPos++;
      if (clr) begin
        mPending = 0;
      end else if (ev) begin
        if (mPending == DEP) mOverflow = 1'b1;
        else mPending++;
      end
    end
  endfunction

  function automatic expect_t modelOutputs();
    expect_t e;
    e.out      = mActive && (mPos < ON_T);
    e.busy     = mActive;
    e.pending  = mPending;
    e.overflow = mOverflow;
    return e;
  endfunction

  task automatic applyStimulus(input bit inBit, input bit clr);
    @(negedge Clock);
    Reset_n = 1'b1;
    In      = inBit;
    Clear   = clr;
    modelStep(inBit, clr);
    expQ.push_back(modelOutputs());
  endtask

  // Reset lands mid-cycle; outputs must clear before any clock edge.
  task automatic applyReset(input bit inBit);
    @(negedge Clock);
    In    = inBit;
    Clear = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("asyncOut", 32'(Out), 32'd0);
    checkOutput("asyncBusy", 32'(Busy), 32'd0);
    checkOutput("asyncPending", 32'(Pending), 32'd0);
    checkOutput("asyncOverflow", 32'(Overflow), 32'd0);
    modelReset();
    expQ.push_back(modelOutputs());
  endtask

  task automatic runPattern(input logic [31:0] inMask, input logic [31:0] clrMask, input int len);
    for (int i = 0; i < len; i++) begin
      applyStimulus(inMask[i], clrMask[i]);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge Clock);
      #1;
      cycleNo++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("out", 32'(Out), 32'(e.out));
        checkOutput("busy", 32'(Busy), 32'(e.busy));
        checkOutput("pending", 32'(Pending), 32'(e.pending));
        checkOutput("overflow", 32'(Overflow), 32'(e.overflow));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog cycle=%0d got=running want=finished", cycleNo);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    modelReset();
    repeat (2) @(negedge Clock);
    checkOutput("resetOut", 32'(Out), 32'd0);
    checkOutput("resetBusy", 32'(Busy), 32'd0);
    checkOutput("resetPending", 32'(Pending), 32'd0);
    checkOutput("resetOverflow", 32'(Overflow), 32'd0);

    runPattern(32'b0, 32'b0, 3);
    runPattern(32'b1, 32'b0, 10);
    runPattern(32'b111, 32'b0, 18);
    runPattern(32'b1111, 32'b0, 18);
    runPattern(32'b100011, 32'b0, 18);
    runPattern(32'b11, 32'b100, 10);
    runPattern(32'b11, 32'b100000, 10);
    runPattern(32'b10001, 32'b10000, 12);

    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyReset(1'b1);
    applyStimulus(1'b1, 1'b0);
    runPattern(32'b0, 32'b0, 8);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset(1'($urandom_range(0, 1)));
      end else begin
        applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
      end
    end
    runPattern(32'b0, 32'b0, 12);

    @(posedge Clock);
    #2;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/pulse_replayer.md
PULSE_REPLAYER -- requirements
Module: pulse_replayer

Interface
REQ-001 SHALL have parameter ON_TICKS, default 5_000_000: Out-high duration per replayed event, in clocks (≥1); 100 ms at 50 MHz.
REQ-002 SHALL have parameter OFF_TICKS, default 5_000_000: mandatory Out-low gap after each high, in clocks (≥1).
REQ-003 SHALL have parameter DEPTH, default 7: maximum queued (pending) events (≥1).
REQ-004 SHALL have port Clock, input, 1: single system clock, rising edge.
REQ-005 SHALL have port Reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port In, input, 1: event strobe, as produced by the key filter; each clock sampled high = one event.
REQ-007 SHALL have port Clear, input, 1: synchronous flush of queued events.
REQ-008 SHALL have port Out, output, 1: registered stretched level, one high pulse per event.
REQ-009 SHALL have port Busy, output, 1: high whenever the state is not IDLE.
REQ-010 SHALL have port Pending, output, $clog2(DEPTH+1): count of queued events not yet started.
REQ-011 SHALL have port Overflow, output, 1: one-clock pulse when an event is dropped.

Function
REQ-012 SHALL use an FSM with states IDLE, ON, OFF and a shared down-counter sized for max(ON_TICKS, OFF_TICKS)-1.
REQ-013 In IDLE with In=1 SHALL go to ON, load counter with ON_TICKS-1, and set Out=1 at the same edge (latency 1 clock).
REQ-014 In ON, Out SHALL stay 1; at counter==0 SHALL go to OFF, load OFF_TICKS-1, clear Out; otherwise decrement.
REQ-015 Out SHALL therefore be high exactly ON_TICKS clocks and low at least OFF_TICKS clocks per event.
REQ-016 In OFF at counter==0: if Pending>0 or In=1 SHALL go to ON (reload ON_TICKS-1, Out=1); otherwise go to IDLE.
REQ-017 In=1 while in ON or OFF (not consumed per REQ-016) SHALL increment Pending.
REQ-018 Restart from queue with In=1 at the same edge: Pending SHALL be unchanged (+1 -1).
REQ-019 Restart with Pending==0 and In=1: the new event SHALL start directly; Pending stays 0.
REQ-020 In=1 requiring an increment while Pending==DEPTH SHALL drop the event, hold Pending, and pulse Overflow for one clock.
REQ-021 Clear=1 SHALL set Pending to 0 at the next edge without aborting the blink in progress; In sampled in the same cycle SHALL be discarded.
REQ-022 Clear at the OFF-terminal edge SHALL take precedence: the FSM goes to IDLE.
REQ-023 Counter and Pending SHALL never wrap; Pending saturates at DEPTH and never goes below 0.

Reset
REQ-024 Reset_n low SHALL asynchronously force state IDLE, counter 0, Pending 0, Out 0, Busy 0, Overflow 0.
REQ-025 Reset asserted mid-blink SHALL abort immediately; no queued event SHALL survive; operation resumes on the first edge after release.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE/ON/OFF) and default ON_TICKS/OFF_TICKS/DEPTH constants.
REQ-027 The loadable down-counter SHALL be one sub-module, tick_counter (load, value, enable, zero flag).

Verification (ON_TICKS=3, OFF_TICKS=2, DEPTH=2)
REQ-028 Single In pulse at cycle 0 -> Out high cycles 1-3, low 4-5, Busy low from cycle 6, Pending 0 throughout.
REQ-029 In at cycles 0, 1, 2 -> Pending 1 then 2; three back-to-back blinks; Out high 1-3, 6-8, 11-13; Busy low at 16.
REQ-030 In at cycles 0-3 -> Pending saturates at 2; Overflow pulses one clock for the cycle-3 event; only three blinks occur.
REQ-031 In at cycle 5 (OFF terminal) with Pending=1 -> Pending stays 1; next blink starts at cycle 6.
REQ-032 Clear at cycle 2 with Pending=1 -> Pending 0 at cycle 3; current blink completes; Busy low at cycle 6.
REQ-033 Reset_n low at cycle 2 of a blink -> Out, Busy, Pending go 0 without a clock edge; In after release starts a fresh blink with 1-clock latency.
